branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
- Supplies the prediction side of the hazard-control interface.
- Looks up the fetch PC in a direct-mapped branch target buffer of 2-bit saturating counters, and drives predicted_branch_taken and predicted_target to pipeline control.
- Carries each prediction down a two-slot shadow pipe (fetch→decode→execute) and compares it with the branch outcome resolved in execute. Drives branch_miss and correct_pc, and trains the table.

Parameters:
- PC_WIDTH, 10, instruction address width.
- INDEX_BITS, 4, BTB index width; entries = 2**INDEX_BITS.
- TAG_BITS, PC_WIDTH-INDEX_BITS, stored tag width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- fetch_pc  in  PC_WIDTH  address of the instruction being fetched
- fetch_valid  in  1  fetch_pc holds a real instruction
- pipe_stall  in  1  fetch/decode latches hold (tied to fetch_latch_stall)
- dec_nop  in  1  decode slot is being squashed this cycle
- ex_branch  in  1  execute holds a conditional branch this cycle
- ex_taken  in  1  resolved direction
- ex_target  in  PC_WIDTH  resolved taken target
- predicted_branch_taken  out  1  combinational prediction for fetch_pc
- predicted_target  out  PC_WIDTH  target paired with the prediction
- branch_miss  out  1  execute outcome disagrees with the carried prediction
- correct_pc  out  PC_WIDTH  redirect address, valid when branch_miss=1

Behaviour:
- Table
  - Per entry: valid (1), tag (TAG_BITS), target (PC_WIDTH), ctr (2).
  - reset_n=0 clears all valid bits and sets ctr=WEAK_NT immediately. Tag and target are don't-care.
- Lookup (0 cycles, combinational)
  - hit = valid[idx] && tag[idx]==fetch_pc[PC_WIDTH-1:INDEX_BITS].
  - predicted_branch_taken = fetch_valid && hit && ctr[1].
  - predicted_target = target[idx], or 0 when no hit.
- Shadow pipe (slots F→D and D→E; each holds valid, pc, pred_taken, pred_target)
  - pipe_stall=1: F→D and D→E hold.
  - dec_nop=1 without a stall: D→E loads valid=0.
  - branch_miss=1 (highest priority): both slots load valid=0 on the next edge.
  - Otherwise F→D captures the lookup result (valid=fetch_valid) and D→E captures F→D.
  - Reset: both slots valid=0.
- Resolution (combinational, in the ex_branch cycle)
  - e = D→E slot. Prediction carried = e.valid && e.pred_taken.
  - branch_miss = ex_branch && (carried != ex_taken || (ex_taken && carried && e.pred_target != ex_target)).
  - correct_pc = ex_taken ? ex_target : e.pc+1, wrapping modulo 2**PC_WIDTH (0x3FF → 0x000).
  - ex_branch with e.valid=0 is treated as predicted not-taken.
  - Reset value: branch_miss=0, correct_pc=0.
- Training (clock edge of the ex_branch cycle, index from e.pc)
  - Tag hit: ctr saturates toward the outcome (+1 if taken, max 3; -1 if not, min 0). Target is overwritten when taken.
  - Tag miss and taken: allocate; valid=1, tag, target=ex_target, ctr=WEAK_T.
  - Tag miss and not taken: no change.
- Counter state machine
  - States: STRONG_NT(0), WEAK_NT(1), WEAK_T(2), STRONG_T(3).
  - Taken moves up one state; not-taken moves down one; both saturate at the ends.
- Simultaneous events
  - Training and lookup hit the same index in one cycle: lookup sees the old entry (write-after-read).
  - branch_miss and pipe_stall together: the flush wins.
- Reset mid-operation: in-flight predictions are discarded, no update is written, and outputs go to reset values asynchronously.

Decomposition:
- Package rat_pipe_pkg holds:
  - typedef enum ctr_t {STRONG_NT, WEAK_NT, WEAK_T, STRONG_T};
  - struct pred_slot_t {valid, pc, pred_taken, pred_target};
  - constants PC_WIDTH_DEFAULT=10 and BTB_INDEX_BITS_DEFAULT=4.
- One sub-module, btb_table: storage, combinational read port, and one synchronous write port with saturating-counter update. The top module holds the shadow pipe and the miss compare.

Test Plan:
1. Reset, then fetch_pc=0x040 with fetch_valid=1 → predicted_branch_taken=0. Two cycles later ex_branch=1, ex_taken=1, ex_target=0x080 → branch_miss=1, correct_pc=0x080; entry 0 allocated WEAK_T.
2. Re-fetch 0x040 → predicted_branch_taken=1, predicted_target=0x080. Resolve taken to 0x080 → branch_miss=0; ctr becomes STRONG_T.
3. Entry at STRONG_T; resolve 0x040 not-taken twice → first resolution gives branch_miss=1, correct_pc=0x041, ctr=WEAK_T; second gives ctr=WEAK_NT, and the next fetch of 0x040 predicts 0.
4. Aliasing: train 0x040, then fetch 0x050 (same index, different tag) → no prediction. A taken resolve of 0x050 to 0x010 replaces the tag.
5. Predicted taken, resolved taken to 0x090 instead of 0x080 → branch_miss=1, correct_pc=0x090, target updated. Both shadow slots show valid=0 the next cycle even with pipe_stall=1.
6. pc=0x3FF predicted taken, resolved not-taken → correct_pc=0x000. Assert reset_n=0 mid-flight → branch_miss drops immediately and the table is invalidated.

Source files
------------

// File: rtl/rat_pipe_pkg.sv
// Shared types for the branch predictor: counter states, shadow-pipe slot and defaults.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package rat_pipe_pkg;

   localparam int PC_WIDTH_DEFAULT       = 10;
   localparam int BTB_INDEX_BITS_DEFAULT = 4;

   typedef enum logic [1:0] {
      STRONG_NT = 2'd0,
      WEAK_NT   = 2'd1,
      WEAK_T    = 2'd2,
      STRONG_T  = 2'd3
   } ctr_t;

   // One prediction travelling alongside its instruction.
   // The slot is sized by PC_WIDTH_DEFAULT.
   // Any top that uses it must keep PC_WIDTH at that default.
   typedef struct packed {
      logic                        valid;
      logic [PC_WIDTH_DEFAULT-1:0] pc;
      logic                        pred_taken;
      logic [PC_WIDTH_DEFAULT-1:0] pred_target;
   } pred_slot_t;

   // Saturating step: taken moves one state up, not-taken moves one state down.
   function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
      ctr_t nxt;
      nxt = cur;
      if (taken) begin
         if (cur != STRONG_T) nxt = ctr_t'(cur + 2'd1);
      end else begin
         if (cur != STRONG_NT) nxt = ctr_t'(cur - 2'd1);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Latency: read 0 cycles (combinational); write takes effect on the next clk edge.
// Backpressure: none; a write is accepted every cycle wr_en is high.
// Ports: rd_pc -> rd_hit/rd_taken/rd_target ; wr_en/wr_pc/wr_taken/wr_target train one entry.
module btb_table
   import rat_pipe_pkg::*;
#(
   parameter int PC_WIDTH   = PC_WIDTH_DEFAULT,
   parameter int INDEX_BITS = BTB_INDEX_BITS_DEFAULT,
   parameter int TAG_BITS   = PC_WIDTH - INDEX_BITS
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [PC_WIDTH-1:0] rd_pc,
   output logic                rd_hit,
   output logic                rd_taken,
   output logic [PC_WIDTH-1:0] rd_target,
   input  logic                wr_en,
   input  logic [PC_WIDTH-1:0] wr_pc,
   input  logic                wr_taken,
   input  logic [PC_WIDTH-1:0] wr_target
);

   localparam int ENTRIES = 1 << INDEX_BITS;

   logic [ENTRIES-1:0]  valid_q;
   ctr_t                ctr_q    [ENTRIES];
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   logic [PC_WIDTH-1:0] target_q [ENTRIES];

   logic [INDEX_BITS-1:0] rd_idx;
   logic [INDEX_BITS-1:0] wr_idx;
   logic [TAG_BITS-1:0]   rd_tag;
   logic [TAG_BITS-1:0]   wr_tag;
   logic                  wr_hit;

   assign rd_idx = rd_pc[INDEX_BITS-1:0];
   assign rd_tag = rd_pc[PC_WIDTH-1:INDEX_BITS];
   assign wr_idx = wr_pc[INDEX_BITS-1:0];
   assign wr_tag = wr_pc[PC_WIDTH-1:INDEX_BITS];

   // Reads see the pre-edge contents.
   // A same-cycle write to the read index is therefore not forwarded.
   assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
   assign rd_taken  = (ctr_q[rd_idx] == WEAK_T) || (ctr_q[rd_idx] == STRONG_T);
   assign rd_target = target_q[rd_idx];

   assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= WEAK_NT;
      end else if (wr_en) begin
         if (wr_hit) begin
            ctr_q[wr_idx] <= ctr_next(ctr_q[wr_idx], wr_taken);
         end else if (wr_taken) begin
            valid_q[wr_idx] <= 1'b1;
            ctr_q[wr_idx]   <= WEAK_T;
         end
      end
   end

   // Tag and target need no reset: they are only meaningful while valid is set.
   // On a tag hit the rewrite of the tag leaves it unchanged.
   always_ff @(posedge clk) begin
      if (reset_n && wr_en && wr_taken) begin
         tag_q[wr_idx]    <= wr_tag;
         target_q[wr_idx] <= wr_target;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Branch prediction at fetch, a two-slot shadow pipe to execute, and miss detection with table training.
// Latency: prediction 0 cycles; resolution 0 cycles in the ex_branch cycle; training lands on that cycle's edge.
// Backpressure: pipe_stall holds both shadow slots; a miss flushes them regardless of stall.
// Ports: fetch_pc/fetch_valid -> predicted_branch_taken/predicted_target ;
//        ex_branch/ex_taken/ex_target -> branch_miss/correct_pc ; pipe_stall and dec_nop track the pipeline.
module branch_predictor
   import rat_pipe_pkg::*;
#(
   parameter int PC_WIDTH   = PC_WIDTH_DEFAULT,
   parameter int INDEX_BITS = BTB_INDEX_BITS_DEFAULT,
   parameter int TAG_BITS   = PC_WIDTH - INDEX_BITS
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [PC_WIDTH-1:0] fetch_pc,
   input  logic                fetch_valid,
   input  logic                pipe_stall,
   input  logic                dec_nop,
   input  logic                ex_branch,
   input  logic                ex_taken,
   input  logic [PC_WIDTH-1:0] ex_target,
   output logic                predicted_branch_taken,
   output logic [PC_WIDTH-1:0] predicted_target,
   output logic                branch_miss,
   output logic [PC_WIDTH-1:0] correct_pc
);

   logic                rd_hit;
   logic                rd_taken;
   logic [PC_WIDTH-1:0] rd_target;
   logic                carried;
   logic                miss_raw;
   pred_slot_t          fd_slot;
   pred_slot_t          de_slot;

   btb_table #(
      .PC_WIDTH   (PC_WIDTH),
      .INDEX_BITS (INDEX_BITS),
      .TAG_BITS   (TAG_BITS)
   ) u_btb (
      .clk       (clk),
      .reset_n   (reset_n),
      .rd_pc     (fetch_pc),
      .rd_hit    (rd_hit),
      .rd_taken  (rd_taken),
      .rd_target (rd_target),
      .wr_en     (ex_branch),
      .wr_pc     (de_slot.pc),
      .wr_taken  (ex_taken),
      .wr_target (ex_target)
   );

   assign predicted_branch_taken = fetch_valid && rd_hit && rd_taken;
   assign predicted_target       = rd_hit ? rd_target : '0;

   // An empty execute slot counts as a not-taken prediction.
   assign carried  = de_slot.valid && de_slot.pred_taken;
   assign miss_raw = ex_branch &&
                     ((carried != ex_taken) ||
                      (ex_taken && carried && (de_slot.pred_target != ex_target)));

   // Outputs are forced to their idle values while reset is asserted.
   // This holds even if execute inputs are still active during reset.
   assign branch_miss = reset_n && miss_raw;
   always_comb begin
      correct_pc = '0;
      if (reset_n) begin
         correct_pc = ex_taken ? ex_target : de_slot.pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fd_slot <= '0;
         de_slot <= '0;
      end else if (branch_miss) begin
         fd_slot.valid <= 1'b0;
         de_slot.valid <= 1'b0;
      end else if (!pipe_stall) begin
         fd_slot.valid       <= fetch_valid;
         fd_slot.pc          <= fetch_pc;
         fd_slot.pred_taken  <= predicted_branch_taken;
         fd_slot.pred_target <= predicted_target;
         de_slot             <= fd_slot;
         if (dec_nop) de_slot.valid <= 1'b0;
      end
   end

endmodule
